// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared node-format sizing, node word type and loader state encoding.
// Optional feature macro: LOAD_CHECKSUM_EN (adds the CHECK state).
package dtree_pkg;

    function automatic int node_size_f(input int features, input int coeff_w, input int bias_w);
        return 2 + features + (features - 1) * coeff_w + bias_w + 1;
    endfunction

    function automatic int bytes_per_node_f(input int node_size, input int byte_w);
        return (node_size + byte_w - 1) / byte_w;
    endfunction

    localparam int NODE_SIZE      = node_size_f(3, 2, 10);
    localparam int BYTES_PER_NODE = bytes_per_node_f(NODE_SIZE, 8);

    typedef logic [NODE_SIZE-1:0] node_word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSEMBLE = 3'd1,
        ST_WRITE    = 3'd2,
`ifdef LOAD_CHECKSUM_EN
        ST_CHECK    = 3'd3,
`endif
        ST_DONE     = 3'd4
    } loader_state_t;

endpackage

// File: rtl/node_byte_assembler.sv
// rtl/node_byte_assembler.sv - byte counter and LSB-first byte-slice writer building one node word.
module node_byte_assembler #(
    parameter int NODE_SIZE      = 20,
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_NODE = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [NODE_SIZE-1:0]  o_word,
    output logic                  o_last
);

    localparam int CW = (BYTES_PER_NODE > 1) ? $clog2(BYTES_PER_NODE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_NODE - 1);

    logic [CW-1:0]        r_cnt;
    logic [NODE_SIZE-1:0] r_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_load) begin
                r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
            end
            // Bits of the final byte beyond NODE_SIZE have no destination and are dropped.
            if (i_load) begin
                for (int k = 0; k < BYTES_PER_NODE; k++) begin
                    for (int b = 0; b < BYTE_WIDTH; b++) begin
                        if ((k * BYTE_WIDTH + b < NODE_SIZE) && (r_cnt == CW'(k))) begin
                            r_word[k * BYTE_WIDTH + b] <= i_byte[b];
                        end
                    end
                end
            end
        end
    end

    assign o_word = r_word;
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/dtree_node_loader.sv
// rtl/dtree_node_loader.sv - streams config bytes into node words and writes them to the classifier node memory.
// Optional feature macro: LOAD_CHECKSUM_EN (XOR trailer byte check, drives err).
module dtree_node_loader
    import dtree_pkg::*;
#(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 2,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int CHANNEL_COUNT = 4,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              start,
    input  logic                                              cfg_valid,
    output logic                                              cfg_ready,
    input  logic [BYTE_WIDTH-1:0]                             cfg_data,
    output logic                                              wr_node,
    output logic [$clog2(CHANNEL_COUNT*MAX_CLUSTERS)-1:0]     node_addr,
    output logic [node_size_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH)-1:0] node_data_out,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err
);

    localparam int NODE_BITS  = node_size_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH);
    localparam int NODE_BYTES = bytes_per_node_f(NODE_BITS, BYTE_WIDTH);
    localparam int NODE_COUNT = CHANNEL_COUNT * MAX_CLUSTERS;
    localparam int AW         = $clog2(NODE_COUNT);
    localparam logic [AW-1:0] LAST_IDX = AW'(NODE_COUNT - 1);

    loader_state_t r_state;
    loader_state_t w_next;
    logic [AW-1:0] r_node_idx;
    logic          w_start_load;
    logic          w_hs;
    logic          w_last_byte;
    logic          w_last_node;

    assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hs         = cfg_valid && cfg_ready;
    assign w_last_node  = (r_node_idx == LAST_IDX);

    node_byte_assembler #(
        .NODE_SIZE      (NODE_BITS),
        .BYTE_WIDTH     (BYTE_WIDTH),
        .BYTES_PER_NODE (NODE_BYTES)
    ) u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_start_load || (r_state == ST_WRITE)),
        .i_load  (w_hs && (r_state == ST_ASSEMBLE)),
        .i_byte  (cfg_data),
        .o_word  (node_data_out),
        .o_last  (w_last_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next = ST_ASSEMBLE;
            ST_ASSEMBLE: if (cfg_valid && w_last_byte) w_next = ST_WRITE;
            ST_WRITE: begin
                if (w_last_node) begin
`ifdef LOAD_CHECKSUM_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_DONE;
`endif
                end else begin
                    w_next = ST_ASSEMBLE;
                end
            end
`ifdef LOAD_CHECKSUM_EN
            ST_CHECK:    if (cfg_valid) w_next = ST_DONE;
`endif
            ST_DONE:     if (start) w_next = ST_ASSEMBLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The last node index is held after its write so node_addr never wraps within a load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_node_idx <= '0;
        end else if (w_start_load) begin
            r_node_idx <= '0;
        end else if ((r_state == ST_WRITE) && !w_last_node) begin
            r_node_idx <= r_node_idx + 1'b1;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] r_xor;
    logic                  r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_start_load) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_hs && (r_state == ST_ASSEMBLE)) begin
            r_xor <= r_xor ^ cfg_data;
        end else if (w_hs && (r_state == ST_CHECK)) begin
            r_err <= (cfg_data != r_xor);
        end
    end

    assign err       = r_err;
    assign cfg_ready = (r_state == ST_ASSEMBLE) || (r_state == ST_CHECK);
    assign busy      = (r_state == ST_ASSEMBLE) || (r_state == ST_WRITE) || (r_state == ST_CHECK);
`else
    assign err       = 1'b0;
    assign cfg_ready = (r_state == ST_ASSEMBLE);
    assign busy      = (r_state == ST_ASSEMBLE) || (r_state == ST_WRITE);
`endif

    assign wr_node   = (r_state == ST_WRITE);
    assign node_addr = r_node_idx;
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_dtree_node_loader.sv
// tb/tb_dtree_node_loader.sv - randomized scoreboard bench for dtree_node_loader.
module tb_dtree_node_loader;

    localparam int NODE_SIZE  = 20;
    localparam int BPN        = 3;
    localparam int NODE_COUNT = 20;
    localparam int NB         = NODE_COUNT * BPN;
`ifdef LOAD_CHECKSUM_EN
    localparam int TRAILER = 1;
`else
    localparam int TRAILER = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_ready;
    logic        wr_node;
    logic [4:0]  node_addr;
    logic [19:0] node_data_out;
    logic        busy;
    logic        done;
    logic        err;

    dtree_node_loader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .wr_node       (wr_node),
        .node_addr     (node_addr),
        .node_data_out (node_data_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[NB+1];
    int          exp_addr_q[$];
    logic [31:0] exp_word_q[$];
    int          cyc = 0;
    int          last_wr = -1;
    int          done_due = -1;
    bit          check_gap = 1'b0;
    int          mon_addr;
    logic [31:0] mon_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every wr_node must match the oldest expected node.
    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (wr_node) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_node: addr %0d with nothing pending", node_addr);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    mon_word = exp_word_q.pop_front();
                    check("node_addr", 32'(node_addr), mon_addr);
                    check("node_data", 32'(node_data_out), mon_word);
                    check("ready_in_write", 32'(cfg_ready), 0);
                    if (check_gap && last_wr >= 0) check("wr_gap", cyc - last_wr, BPN + 1);
                    if (TRAILER == 0 && mon_addr == NODE_COUNT - 1) done_due = cyc + 1;
                end
                last_wr = cyc;
            end
            if (done_due == cyc) begin
                check("done_after_last_write", 32'(done), 1);
                check("busy_after_last_write", 32'(busy), 0);
                done_due = -1;
            end
        end
    end

    // Reference model: a node word is its bytes read as a little-endian number, modulo 2^NODE_SIZE.
    task automatic gen_load(input bit fix0, input bit pad, input bit bad_trailer, input int nodes_expected);
        logic [7:0] x;
        longint     full;
        x = 8'h00;
        for (int n = 0; n < NODE_COUNT; n++) begin
            for (int k = 0; k < BPN; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (pad && k == BPN - 1) b = 8'hF5;
                if (fix0 && n == 0) b = (k == 0) ? 8'h21 : (k == 1) ? 8'h43 : 8'h05;
                stream[n * BPN + k] = b;
                x = x ^ b;
            end
        end
        stream[NB] = x ^ {7'd0, bad_trailer};
        for (int n = 0; n < nodes_expected; n++) begin
            full = longint'(stream[n*BPN]) + 256 * longint'(stream[n*BPN+1])
                 + 65536 * longint'(stream[n*BPN+2]);
            exp_addr_q.push_back(n);
            exp_word_q.push_back(32'(full % (longint'(1) << NODE_SIZE)));
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("done_cleared_by_start", 32'(done), 0);
    endtask

    task automatic drive(input int limit, input int duty, input int glitch_at);
        int ptr;
        int guard;
        ptr = 0;
        guard = 0;
        while (ptr < limit) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout: %0d of %0d bytes consumed", ptr, limit);
                break;
            end
            if (glitch_at >= 0) start = (ptr == glitch_at);
            if (int'($urandom_range(99)) < duty) begin
                cfg_valid = 1'b1;
                cfg_data  = stream[ptr];
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = 8'($urandom);
            end
            if (cfg_valid && cfg_ready) ptr++;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("done_reached", 32'(done), 1);
    endtask

    task automatic full_load(input int duty, input bit fix0, input bit pad, input int glitch_at, input bit bad);
        gen_load(fix0, pad, bad, NODE_COUNT);
        last_wr   = -1;
        check_gap = (duty >= 100);
        do_start();
        drive(NB + TRAILER, duty, glitch_at);
        wait_done();
        check("err_at_done", 32'(err), (TRAILER != 0) ? 32'(bad) : 0);
        check("addr_held_last", 32'(node_addr), NODE_COUNT - 1);
        check("busy_at_done", 32'(busy), 0);
        check("pending_nodes", exp_addr_q.size(), 0);
        // Extra bytes offered in DONE must not be taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = 8'($urandom);
            check("ready_in_done", 32'(cfg_ready), 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("done_held", 32'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_wr_node", 32'(wr_node), 0);
        check("rst_node_addr", 32'(node_addr), 0);
        check("rst_node_data", 32'(node_data_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        reset_n = 1'b1;

        full_load(100, 1'b1, 1'b0, -1, 1'b0);
        full_load(30, 1'b0, 1'b0, -1, 1'b0);
        full_load(100, 1'b0, 1'b1, -1, 1'b0);
        full_load(30, 1'b0, 1'b0, 10, 1'b0);
        if (TRAILER != 0) full_load(100, 1'b0, 1'b0, -1, 1'b1);

        // Reset after the first byte of node 7 has been accepted.
        gen_load(1'b0, 1'b0, 1'b0, 7);
        last_wr   = -1;
        check_gap = 1'b0;
        do_start();
        drive(7 * BPN + 1, 100, -1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_wr_node", 32'(wr_node), 0);
        check("midrst_node_addr", 32'(node_addr), 0);
        check("midrst_node_data", 32'(node_data_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cfg_ready", 32'(cfg_ready), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_pending", exp_addr_q.size(), 0);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'(busy), 0);

        full_load(100, 1'b0, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtree_node_loader.md
Name: dtree_node_loader

Overview:
- Writer side of the classifier's node-memory initialisation interface (wr_node / node_addr / node_data_in).
- Accepts a byte stream from the configuration port through a valid/ready handshake.
- Assembles each stream into NODE_SIZE-bit tree-node words and issues one wr_node pulse per node, for CHANNEL_COUNT*MAX_CLUSTERS nodes.
- Signals done so the classifier's ready path can be released.
- Sits between the host configuration interface and the dtree classifier.

Parameters:
- FEATURES, 3, input features per node
- COEFF_WIDTH, 2, hyperplane coefficient width
- BIAS_WIDTH, 10, hyperplane bias width
- MAX_CLUSTERS, 5, nodes per channel
- CHANNEL_COUNT, 4, channels
- BYTE_WIDTH, 8, configuration stream word width
- Derived, not overridable:
  - NODE_SIZE = 2+FEATURES+(FEATURES-1)*COEFF_WIDTH+BIAS_WIDTH+1 (20 at defaults)
  - BYTES_PER_NODE = ceil(NODE_SIZE/BYTE_WIDTH) (3)
  - NODE_COUNT = CHANNEL_COUNT*MAX_CLUSTERS (20)

Ports:
- Timing: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled in IDLE and DONE only
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a byte this cycle
- cfg_data  in  BYTE_WIDTH  configuration byte, node bits LSB-first
- wr_node  out  1  one-cycle node write strobe
- node_addr  out  $clog2(NODE_COUNT)  index of node being written
- node_data_out  out  NODE_SIZE  assembled node word
- busy  out  1  load in progress
- done  out  1  all nodes written; held until next start
- err  out  1  checksum mismatch (LOAD_CHECKSUM_EN only; otherwise tied 0)

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; cfg_ready, wr_node, busy, done and err=0; node_addr=0; node_data_out=0; byte and node counters=0.
- FSM states: IDLE, ASSEMBLE, WRITE, CHECK (macro only), DONE.
- IDLE:
  - start=1 -> ASSEMBLE next cycle.
  - Clear counters and err; busy=1 from that edge.
- ASSEMBLE:
  - cfg_ready=1, combinational from state only; it does not depend on cfg_valid.
  - A byte is accepted on cfg_valid&cfg_ready. Byte k of a node loads node_data_out[k*BYTE_WIDTH +: BYTE_WIDTH], truncated at NODE_SIZE. Upper pad bits of the last byte are ignored.
  - After accepting byte BYTES_PER_NODE-1 -> WRITE.
- WRITE (exactly one cycle):
  - cfg_ready=0; wr_node=1; node_addr=current node index; node_data_out stable.
  - Next state: if node index = NODE_COUNT-1, go to CHECK (macro) or DONE; node_addr then holds NODE_COUNT-1.
  - Otherwise node index+1, byte counter=0, -> ASSEMBLE.
- DONE:
  - done=1, busy=0, cfg_ready=0.
  - start=1 -> clear done and begin a new load as from IDLE.
  - Downstream must be reset before a reload, because the classifier ignores writes once its memory is full.
- Latency and throughput:
  - wr_node asserts on the cycle after the final byte's handshake.
  - Peak rate is one node per BYTES_PER_NODE+1 cycles (4 at defaults).
- Stalls: cfg_valid low during ASSEMBLE holds all state. No timeout.
- start is ignored while busy.
- Bytes presented while cfg_ready=0 are not consumed.
- Node_addr wrap: never exceeds NODE_COUNT-1; there is no wrap within one load.
- Reset asserted mid-load: the partial node is discarded and no wr_node is issued. The next load starts at node 0.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHECK with cfg_ready=1 and accept one trailer byte.
  - Compare the trailer against the running XOR of every accepted node byte.
  - Mismatch sets err=1, held until the next start. Then enter DONE; done asserts regardless of err.
- Undefined:
  - No CHECK state and no XOR register; err is tied 0.
  - Last WRITE -> DONE.

Decomposition:
- Package dtree_pkg:
  - NODE_SIZE and BYTES_PER_NODE as constant functions of the parameters.
  - Loader state enum typedef.
  - node_word_t typedef (NODE_SIZE bits), also reused by the classifier side.
- One sub-module, node_byte_assembler: byte counter plus bit-slice write into the node word, with clear and load-enable inputs.
- The FSM, node counter and checksum stay in dtree_node_loader.

Test Plan:
- Nominal load, defaults: start, then 60 bytes back-to-back with cfg_valid=1 -> 20 wr_node pulses, 4 cycles apart, node_addr 0..19. Node 0 bytes 0x21,0x43,0x05 -> node_data_out=20'h54321. done=1 one cycle after the last WRITE.
- Backpressure/gaps: random cfg_valid duty 30% -> identical node words and addresses; no wr_node while bytes are pending.
- Pad-bit truncation: last byte of each node 0xF5 -> bits [19:16]=4'h5; the pad nibble is discarded.
- Reset mid-node: reset_n low after 1 byte of node 7 -> all outputs 0 immediately, no wr_node for node 7. A restart writes from node_addr 0.
- Restart and ignored start: start pulsed during ASSEMBLE -> no effect. start in DONE -> done=0 next cycle and a new sequence from node 0.
- Checksum (LOAD_CHECKSUM_EN): correct XOR trailer -> err=0, done=1. Trailer XORed with 0x01 -> err=1, done=1. Macro undefined -> no trailer accepted, err stays 0.
